// File: rtl/a2wb_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : a2wb_bus_master
// Description : Wishbone master for the A2 core bridge. Arbitrates round-robin
//               among per-core command entries and runs each accepted command
//               as one classic single-beat Wishbone cycle. The result goes back
//               to the granting core as a one-cycle response pulse.
// Ports       : clk, rst               - clock, async active-high reset
//               req_valid/we/sel/adr/datw/ext - per-core command entries (in)
//               req_ready              - one-cycle accept pulse per core (out)
//               rsp_valid/rsp_datr/rsp_err - per-core completion pulse,
//                                        shared read data and error flag (out)
//               wb_cyc/stb/we/sel/adr/datw/ext - Wishbone request (out)
//               wb_ack/wb_err/wb_datr  - Wishbone slave response (in)
// Revision    : 1.0 - initial release
// ============================================================================
module a2wb_bus_master #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      req_valid,
    input  logic [NUM_CORES-1:0]      req_we,
    input  logic [4*NUM_CORES-1:0]    req_sel,
    input  logic [32*NUM_CORES-1:0]   req_adr,
    input  logic [32*NUM_CORES-1:0]   req_datw,
    input  logic [8*NUM_CORES-1:0]    req_ext,
    output logic [NUM_CORES-1:0]      req_ready,
    output logic [NUM_CORES-1:0]      rsp_valid,
    output logic [31:0]               rsp_datr,
    output logic                      rsp_err,
    output logic                      wb_cyc,
    output logic                      wb_stb,
    output logic                      wb_we,
    output logic [3:0]                wb_sel,
    output logic [31:0]               wb_adr,
    output logic [31:0]               wb_datw,
    output logic [7:0]                wb_ext,
    input  logic                      wb_ack,
    input  logic                      wb_err,
    input  logic [31:0]               wb_datr
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_BUS     = 2'd1;
    localparam logic [1:0] c_S_RESP    = 2'd2;
    localparam logic [1:0] c_LAST_INIT = 2'(NUM_CORES - 1);
    localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT - 1);

    // Registered state and outputs
    logic [1:0]            r_state;
    logic [1:0]            r_last_grant;
    logic [1:0]            r_grant;
    logic [7:0]            r_cnt;
    logic [NUM_CORES-1:0]  r_req_ready;
    logic [NUM_CORES-1:0]  r_rsp_valid;
    logic [31:0]           r_rsp_datr;
    logic                  r_rsp_err;
    logic                  r_wb_cyc;
    logic                  r_wb_stb;
    logic                  r_wb_we;
    logic [3:0]            r_wb_sel;
    logic [31:0]           r_wb_adr;
    logic [31:0]           r_wb_datw;
    logic [7:0]            r_wb_ext;

    // Next-state values
    logic [1:0]            w_state_nxt;
    logic [1:0]            w_last_grant_nxt;
    logic [1:0]            w_grant_nxt;
    logic [7:0]            w_cnt_nxt;
    logic [NUM_CORES-1:0]  w_req_ready_nxt;
    logic [NUM_CORES-1:0]  w_rsp_valid_nxt;
    logic [31:0]           w_rsp_datr_nxt;
    logic                  w_rsp_err_nxt;
    logic                  w_wb_cyc_nxt;
    logic                  w_wb_stb_nxt;
    logic                  w_wb_we_nxt;
    logic [3:0]            w_wb_sel_nxt;
    logic [31:0]           w_wb_adr_nxt;
    logic [31:0]           w_wb_datw_nxt;
    logic [7:0]            w_wb_ext_nxt;

    // Arbitration and bus-termination decode
    logic                  w_found;
    logic [1:0]            w_grant;
    logic                  w_timeout;
    logic                  w_done;

    // Round-robin search: start one past the last grant and wrap. Only
    // indices below NUM_CORES are ever visited, so absent cores never win.
    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_grant = 2'd0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            v_idx = int'(r_last_grant) + k;
            if (v_idx >= NUM_CORES) begin
                v_idx = v_idx - NUM_CORES;
            end
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_grant = 2'(v_idx);
            end
        end
    end

    assign w_timeout = (r_cnt == c_TO_LAST);
    assign w_done    = wb_err | wb_ack | w_timeout;

    // ------------------------------------------------------------------
    // State register (also holds all registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_last_grant <= c_LAST_INIT;
            r_grant      <= 2'd0;
            r_cnt        <= 8'd0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_datr   <= 32'd0;
            r_rsp_err    <= 1'b0;
            r_wb_cyc     <= 1'b0;
            r_wb_stb     <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_sel     <= 4'd0;
            r_wb_adr     <= 32'd0;
            r_wb_datw    <= 32'd0;
            r_wb_ext     <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_datr   <= w_rsp_datr_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_wb_cyc     <= w_wb_cyc_nxt;
            r_wb_stb     <= w_wb_stb_nxt;
            r_wb_we      <= w_wb_we_nxt;
            r_wb_sel     <= w_wb_sel_nxt;
            r_wb_adr     <= w_wb_adr_nxt;
            r_wb_datw    <= w_wb_datw_nxt;
            r_wb_ext     <= w_wb_ext_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_found) w_state_nxt = c_S_BUS;
            c_S_BUS:  if (w_done)  w_state_nxt = c_S_RESP;
            c_S_RESP: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs. Pulses default
    // low; bus fields and read data hold unless explicitly updated.
    // ------------------------------------------------------------------
    always_comb begin
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_cnt_nxt        = r_cnt;
        w_req_ready_nxt  = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_datr_nxt   = r_rsp_datr;
        w_rsp_err_nxt    = r_rsp_err;
        w_wb_cyc_nxt     = r_wb_cyc;
        w_wb_stb_nxt     = r_wb_stb;
        w_wb_we_nxt      = r_wb_we;
        w_wb_sel_nxt     = r_wb_sel;
        w_wb_adr_nxt     = r_wb_adr;
        w_wb_datw_nxt    = r_wb_datw;
        w_wb_ext_nxt     = r_wb_ext;

        case (r_state)
            c_S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt      = w_grant;
                    w_last_grant_nxt = w_grant;
                    w_cnt_nxt        = 8'd0;
                    w_wb_cyc_nxt     = 1'b1;
                    w_wb_stb_nxt     = 1'b1;
                    w_wb_we_nxt      = req_we[w_grant];
                    w_wb_sel_nxt     = req_sel[4*int'(w_grant) +: 4];
                    w_wb_adr_nxt     = req_adr[32*int'(w_grant) +: 32];
                    w_wb_datw_nxt    = req_datw[32*int'(w_grant) +: 32];
                    w_wb_ext_nxt     = req_ext[8*int'(w_grant) +: 8];
                    for (int i = 0; i < NUM_CORES; i++) begin
                        w_req_ready_nxt[i] = (w_grant == 2'(i));
                    end
                end
            end
            c_S_BUS: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (w_done) begin
                    w_cnt_nxt    = 8'd0;
                    w_wb_cyc_nxt = 1'b0;
                    w_wb_stb_nxt = 1'b0;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        w_rsp_valid_nxt[i] = (r_grant == 2'(i));
                    end
                    // Error beats a simultaneous ack; a timeout is only
                    // reached when the slave gave neither.
                    if (wb_err) begin
                        w_rsp_err_nxt  = 1'b1;
                        w_rsp_datr_nxt = 32'd0;
                    end else if (wb_ack) begin
                        w_rsp_err_nxt  = 1'b0;
                        w_rsp_datr_nxt = r_wb_we ? 32'd0 : wb_datr;
                    end else begin
                        w_rsp_err_nxt  = 1'b1;
                        w_rsp_datr_nxt = 32'd0;
                    end
                end
            end
            c_S_RESP: begin
                w_rsp_err_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_datr  = r_rsp_datr;
    assign rsp_err   = r_rsp_err;
    assign wb_cyc    = r_wb_cyc;
    assign wb_stb    = r_wb_stb;
    assign wb_we     = r_wb_we;
    assign wb_sel    = r_wb_sel;
    assign wb_adr    = r_wb_adr;
    assign wb_datw   = r_wb_datw;
    assign wb_ext    = r_wb_ext;

endmodule
`default_nettype wire

// File: tb/tb_a2wb_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2wb_bus_master
// Description : Self-checking bench for a2wb_bus_master. Cores hold random
//               commands; a transaction-level model predicts the round-robin
//               grant order, bus fields, response latency and response data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2wb_bus_master;

    localparam int NC = 4;
    localparam int TO = 8;

    // Slave response kinds
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NC-1:0]        req_valid;
    logic [NC-1:0]        req_we;
    logic [4*NC-1:0]      req_sel;
    logic [32*NC-1:0]     req_adr;
    logic [32*NC-1:0]     req_datw;
    logic [8*NC-1:0]      req_ext;
    logic [NC-1:0]        req_ready;
    logic [NC-1:0]        rsp_valid;
    logic [31:0]          rsp_datr;
    logic                 rsp_err;
    logic                 wb_cyc, wb_stb, wb_we;
    logic [3:0]           wb_sel;
    logic [31:0]          wb_adr, wb_datw;
    logic [7:0]           wb_ext;
    logic                 wb_ack, wb_err;
    logic [31:0]          wb_datr;

    a2wb_bus_master #(.NUM_CORES(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
        .req_adr(req_adr), .req_datw(req_datw), .req_ext(req_ext),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_datr(rsp_datr),
        .rsp_err(rsp_err), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_datw(wb_datw), .wb_ext(wb_ext),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_datr(wb_datr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-core commands and the slave behaviour planned for each
    logic [NC-1:0] pend;
    logic          c_we   [NC];
    logic [3:0]    c_sel  [NC];
    logic [31:0]   c_adr  [NC];
    logic [31:0]   c_datw [NC];
    logic [7:0]    c_ext  [NC];
    int            p_wait [NC];
    int            p_kind [NC];
    logic [31:0]   p_rdat [NC];
    int            last_g;

    function automatic int rr_next(input int last, input logic [NC-1:0] p);
        for (int k = 1; k <= NC; k++) begin
            if (p[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    task automatic rand_cmd(input int c);
        int r;
        c_we[c]   = 1'($urandom_range(0, 1));
        c_sel[c]  = 4'($urandom);
        c_adr[c]  = $urandom;
        c_datw[c] = $urandom;
        c_ext[c]  = 8'($urandom);
        p_wait[c] = $urandom_range(0, 4);
        p_rdat[c] = $urandom;
        r = $urandom_range(0, 9);
        p_kind[c] = (r <= 5) ? K_ACK : (r <= 7) ? K_ERR : (r == 8) ? K_BOTH : K_NONE;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NC; i++) begin
            req_valid[i]          = pend[i];
            req_we[i]             = c_we[i];
            req_sel[4*i +: 4]     = c_sel[i];
            req_adr[32*i +: 32]   = c_adr[i];
            req_datw[32*i +: 32]  = c_datw[i];
            req_ext[8*i +: 8]     = c_ext[i];
        end
    endtask

    // Called at a negedge with the DUT idle; serves every core in mask.
    task automatic run_round(input logic [NC-1:0] mask);
        int g, n, lat, cyc_cnt, exp_len;
        bit seen;
        logic [31:0] exp_d;
        logic        exp_e;
        pend = mask;
        drive_req();
        while (pend != '0) begin
            g = rr_next(last_g, pend);
            lat = 0;
            do begin @(negedge clk); lat++; end while (req_ready == '0 && lat < 6);
            check("ready_lat", lat, 1);
            check("grant", req_ready, 1 << g);
            check("cyc_stb", {wb_cyc, wb_stb}, 2'b11);
            check("wb_we", wb_we, c_we[g]);
            check("wb_sel", wb_sel, c_sel[g]);
            check("wb_adr", wb_adr, c_adr[g]);
            check("wb_datw", wb_datw, c_datw[g]);
            check("wb_ext", wb_ext, c_ext[g]);
            pend[g] = 1'b0;
            drive_req();

            exp_len = (p_kind[g] == K_NONE) ? TO : p_wait[g] + 1;
            n = 0; cyc_cnt = 0; seen = 0;
            while (!seen && n < TO + 4) begin
                if (wb_cyc) cyc_cnt++;
                wb_ack  = (n == p_wait[g]) && (p_kind[g] == K_ACK || p_kind[g] == K_BOTH);
                wb_err  = (n == p_wait[g]) && (p_kind[g] == K_ERR || p_kind[g] == K_BOTH);
                wb_datr = (n == p_wait[g]) ? p_rdat[g] : $urandom;
                @(negedge clk);
                n++;
                wb_ack = 1'b0;
                wb_err = 1'b0;
                if (rsp_valid != '0) seen = 1;
            end
            exp_e = (p_kind[g] != K_ACK);
            exp_d = (p_kind[g] == K_ACK && !c_we[g]) ? p_rdat[g] : 32'd0;
            check("cyc_len", cyc_cnt, exp_len);
            check("rsp_lat", n, exp_len);
            check("rsp_valid", rsp_valid, 1 << g);
            check("rsp_err", rsp_err, exp_e);
            check("rsp_datr", rsp_datr, exp_d);
            check("cyc_drop", {wb_cyc, wb_stb}, 2'b00);
            check("adr_hold", wb_adr, c_adr[g]);
            @(negedge clk);
            check("rsp_pulse", {rsp_valid, rsp_err, req_ready}, '0);
            check("datr_hold", rsp_datr, exp_d);
            last_g = g;
        end
    endtask

    initial begin
        rst = 1'b1;
        pend = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_datr = 32'd0;
        for (int i = 0; i < NC; i++) rand_cmd(i);
        drive_req();
        last_g = NC - 1;
        repeat (3) @(negedge clk);
        check("rst_outs", {req_ready, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we, wb_sel}, '0);
        check("rst_data", {rsp_datr, wb_adr}, '0);
        check("rst_wdat", {wb_datw, wb_ext}, '0);
        rst = 1'b0;
        @(negedge clk);

        // All cores at once after reset, then cores 0 and 2
        for (int i = 0; i < NC; i++) rand_cmd(i);
        run_round(4'b1111);
        for (int i = 0; i < NC; i++) rand_cmd(i);
        run_round(4'b0101);

        // Core 0 zero-wait read
        rand_cmd(0);
        c_we[0] = 1'b0; c_adr[0] = 32'h0000_1000;
        p_wait[0] = 0; p_kind[0] = K_ACK; p_rdat[0] = 32'hDEAD_BEEF;
        run_round(4'b0001);

        // Core 1 write with 3 wait states
        rand_cmd(1);
        c_we[1] = 1'b1; c_adr[1] = 32'h10; c_sel[1] = 4'b0011; c_datw[1] = 32'h0000_A5A5;
        p_wait[1] = 3; p_kind[1] = K_ACK;
        run_round(4'b0010);

        // Ack and err together on a read
        rand_cmd(2);
        c_we[2] = 1'b0; p_wait[2] = 1; p_kind[2] = K_BOTH;
        run_round(4'b0100);

        // Silent slave
        rand_cmd(3);
        p_kind[3] = K_NONE;
        run_round(4'b1000);

        // Random rounds
        for (int r = 0; r < 40; r++) begin
            logic [NC-1:0] m;
            for (int i = 0; i < NC; i++) rand_cmd(i);
            m = NC'($urandom_range(1, (1 << NC) - 1));
            run_round(m);
        end

        // Reset in the middle of a bus cycle
        rand_cmd(1);
        p_kind[1] = K_NONE;
        pend = 4'b0010;
        drive_req();
        @(negedge clk);
        check("rst_pre_grant", req_ready, 4'b0010);
        pend = '0;
        drive_req();
        repeat (2) @(negedge clk);
        check("rst_pre_cyc", wb_cyc, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_cyc", {wb_cyc, wb_stb}, 2'b00);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, '0);
        end
        rst = 1'b0;
        last_g = NC - 1;
        @(negedge clk);
        check("post_rst_no_rsp", rsp_valid, '0);
        for (int i = 0; i < NC; i++) rand_cmd(i);
        run_round(4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
